// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types and constants for the debug PC reporter
package debug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int BYTES_PER_REPORT     = 4;
  localparam int BITS_PER_BYTE        = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Byte 0 of a report is the most significant byte of the word.
  function automatic logic [7:0] report_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/debug_baud_tick.sv
// rtl/debug_baud_tick.sv - baud counter, one-cycle tick on the last cycle of each bit
module debug_baud_tick
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !restart && (cnt_q == LAST);

endmodule

// File: rtl/debug_pc_tx.sv
// rtl/debug_pc_tx.sv - captures a 32-bit PC and sends it MSB byte first over UART 8N1
module debug_pc_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        send,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_REPORT - 1);
  localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);

  state_e      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;
  logic [7:0]  cur_byte;

  // Held in restart while idle so the first bit of a report gets a full period.
  debug_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(state_q == IDLE),
    .tick   (tick)
  );

  assign cur_byte = report_byte(shadow_q, byte_idx_q);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (send) begin
          state_d    = START;
          shadow_d   = pc;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_d];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 2'd1;
            bit_idx_d  = '0;
            tx_d       = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_debug_pc_tx.sv
// tb/tb_debug_pc_tx.sv - scoreboard bench: time-window model plus UART frame decoder
module tb_debug_pc_tx;

  localparam int CPB    = 4;
  localparam int REPORT = 40 * CPB;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        send  = 1'b0;
  logic [31:0] pc    = '0;
  logic        tx, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  debug_pc_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pc   (pc),
    .send (send),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a report accepted at cycle a keeps busy for cycles a..a+159,
  // pulses done at a+160, and the next request is taken from cycle a+161 on.
  logic [7:0] exp_q[$];
  longint     cyc      = 0;
  longint     acc      = -1;
  logic       busy_exp = 1'b0;
  logic       done_exp = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (send && (acc < 0 || cyc - acc >= REPORT + 1)) begin
        acc = cyc;
        for (int b = 3; b >= 0; b--) exp_q.push_back(pc[8*b +: 8]);
      end
      busy_exp = (acc >= 0) && (cyc - acc < REPORT);
      done_exp = (acc >= 0) && (cyc - acc == REPORT);
    end
  end

  always @(negedge rst_n) begin
    acc = -1;
    exp_q.delete();
    busy_exp = 1'b0;
    done_exp = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, busy_exp);
      check("done", done, done_exp);
      if (!busy_exp) check("tx_idle", tx, 1'b1);
    end
  end

  // Frame decoder: every bit must hold for CPB samples taken mid-cycle.
  task automatic decode_frame();
    logic [9:0] bits;
    logic       first;
    logic       consistent;
    bit         aborted;
    aborted = 0;
    bits    = '0;
    for (int b = 0; b < 10; b++) begin
      consistent = 1'b1;
      first      = 1'b0;
      for (int s = 0; s < CPB; s++) begin
        if (!(b == 0 && s == 0)) @(negedge clk);
        if (!rst_n) aborted = 1;
        if (s == 0) first = tx;
        else if (tx !== first) consistent = 1'b0;
      end
      if (aborted) return;
      check("bit_hold", consistent, 1'b1);
      bits[b] = first;
    end
    check("start_bit", bits[0], 1'b0);
    check("stop_bit", bits[9], 1'b1);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL byte: got %h expected none", bits[8:1]);
    end else begin
      check("byte", bits[8:1], exp_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) decode_frame();
    end
  end

  task automatic drive(input logic s, input logic [31:0] p);
    @(posedge clk);
    #2;
    send = s;
    pc   = p;
  endtask

  task automatic idle(input int n);
    drive(1'b0, pc);
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single report
    drive(1'b1, 32'h12345678);
    idle(180);

    // Second request mid-report must be ignored
    drive(1'b1, 32'hA5A5A5A5);
    idle(50);
    drive(1'b1, 32'h00000000);
    idle(130);

    // Continuous send: back-to-back reports
    drive(1'b1, 32'h00000001);
    repeat (3 * (REPORT + 1) + 5) @(posedge clk);
    idle(170);

    // Reset during the second byte
    drive(1'b1, 32'hFFFF0000);
    idle(55);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 32'hDEADBEEF);
    idle(170);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 15) == 0), $urandom);
    end
    drive(1'b0, 32'h0);

    begin
      int budget;
      budget = 400;
      while ((exp_q.size() != 0 || busy_exp) && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      repeat (4) @(posedge clk);
      check("drained", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_pc_tx.md
DEBUG_PC_TX -- requirements
Module: debug_pc_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pc  input  32  program counter value to report.
REQ-005 send  input  1  request to capture pc and transmit it; sampled each cycle.
REQ-006 tx  output  1  UART serial line, 8N1, idle high.
REQ-007 busy  output  1  high while a 4-byte report is in progress.
REQ-008 done  output  1  one-cycle pulse when a report completes.

Function
REQ-009 FSM states SHALL be IDLE, START, DATA, STOP; encoding comes from the shared package.
REQ-010 In IDLE with send=1, block SHALL latch pc into a 32-bit shadow register, clear byte index to 0, enter START; busy=1 and tx=0 from the next cycle.
REQ-011 send while busy=1 SHALL be ignored; the shadow register SHALL not change during a report.
REQ-012 Bytes SHALL be sent MSB byte first: shadow[31:24], [23:16], [15:8], [7:0].
REQ-013 Each byte frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-014 START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8th data bit; STOP->START for byte index 0..2 (index increments); STOP->IDLE after byte index 3.
REQ-015 No idle gap between bytes: stop bit of byte n immediately followed by start bit of byte n+1.
REQ-016 A report SHALL occupy exactly 40*CLKS_PER_BIT cycles from first tx low to return to IDLE.
REQ-017 On the STOP->IDLE transition, done SHALL pulse high one cycle; busy SHALL be 0 in that same cycle.
REQ-018 send=1 in the done cycle SHALL be accepted as a new request (back-to-back reports, no gap).
REQ-019 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit counter 0..7; byte index 0..3; all wrap-free within a report.
REQ-020 tx, busy, done SHALL be driven from registers (glitch-free).

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, tx=1, busy=0, done=0, all counters and shadow register 0.
REQ-022 Reset asserted mid-report SHALL abort the report; no done pulse; line returns to idle high.
REQ-023 After rst_n deasserts, first send SHALL be honoured no earlier than the first rising edge with rst_n high.

Structure
REQ-024 Shared package debug_pkg SHALL hold the FSM state type, BYTES_PER_REPORT=4, BITS_PER_BYTE=8, default CLKS_PER_BIT.
REQ-025 Baud timing SHALL be a sub-module debug_baud_tick (counter with restart input, one-cycle tick output), instantiated once.

Verification (CLKS_PER_BIT=4 in simulation)
REQ-026 pc=0x12345678, send one cycle -> tx decodes bytes 0x12,0x34,0x56,0x78 in order; busy high 160 cycles; single done pulse.
REQ-027 pc=0xA5A5A5A5 send, pc changed to 0 and send pulsed again mid-report -> transmitted bytes all 0xA5; only one done.
REQ-028 send held high continuously, pc=0x00000001 -> consecutive reports with no idle cycle between; tx low exactly one cycle after each done.
REQ-029 rst_n pulsed low during second byte of pc=0xFFFF0000 -> tx=1, busy=0 same cycle as reset assertion; no done; subsequent send of 0xDEADBEEF transmits correctly.
REQ-030 Bit-timing check: every tx transition spaced in multiples of 4 cycles; stop bits read 1; start bits read 0.
